// File: rtl/seq_det_pkg.sv
// Shared encodings for the 101 sequence detector and its serial feeder.
package seq_det_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_SHIFT      = 2'b01,
        ST_SHIFT_HOLD = 2'b10
    } ser_state_e;

    // Detector states: how much of the 101 pattern has been seen so far.
    typedef enum logic [1:0] {
        DET_S0   = 2'b00,
        DET_S1   = 2'b01,
        DET_S10  = 2'b10,
        DET_S101 = 2'b11
    } det_state_e;

    localparam int unsigned SER_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/seq_bit_serializer_if.sv
// Parallel-in handshake plus serial-out bundle of the bit serializer.
interface seq_bit_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_ready;
    logic             en;
    logic             serial_bit;
    logic             serial_valid;
    logic             word_done;

    modport master (
        output s_data, s_valid, en,
        input  s_ready, serial_bit, serial_valid, word_done
    );

    modport slave (
        input  s_data, s_valid, en,
        output s_ready, serial_bit, serial_valid, word_done
    );
endinterface

// File: rtl/ser_shift_reg.sv
// Loadable shift register that presents its next outgoing bit in either order.
module ser_shift_reg #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    output logic             bit_out
);

    logic [WIDTH-1:0] sr_q;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= load_data;
        end else if (shift) begin
            if (MSB_FIRST) begin
                sr_q <= {sr_q[WIDTH-2:0], 1'b0};
            end else begin
                sr_q <= {1'b0, sr_q[WIDTH-1:1]};
            end
        end
    end

    assign bit_out = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/seq_bit_serializer.sv
// Word-to-bit serializer feeding the 101 detector; one shift word plus one held word.
module seq_bit_serializer
    import seq_det_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic                 clk,
    input  logic                 arst,
    seq_bit_serializer_if.slave  bus
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    ser_state_e       state;
    logic [WIDTH-1:0] hold_q;
    logic [CNT_W-1:0] bit_cnt;

    logic             accept;
    logic             consume;
    logic             last_bit;
    logic             sr_load;
    logic             sr_shift;
    logic [WIDTH-1:0] sr_load_data;
    logic             cur_bit;

    assign bus.s_ready      = (state != ST_SHIFT_HOLD);
    assign bus.serial_valid = (state != ST_IDLE);
    assign accept           = bus.s_valid & bus.s_ready;
    assign consume          = bus.serial_valid & bus.en;
    assign last_bit         = consume & (bit_cnt == CNT_LAST);
    assign bus.word_done    = last_bit;
    assign bus.serial_bit   = (state == ST_IDLE) ? IDLE_BIT : cur_bit;

    // Shift-register control: a held word wins over a fresh one at word end.
    always_comb begin
        sr_load      = 1'b0;
        sr_shift     = 1'b0;
        sr_load_data = bus.s_data;
        unique case (state)
            ST_IDLE: begin
                sr_load = accept;
            end
            ST_SHIFT: begin
                if (last_bit) sr_load  = accept;
                else          sr_shift = consume;
            end
            ST_SHIFT_HOLD: begin
                if (last_bit) begin
                    sr_load      = 1'b1;
                    sr_load_data = hold_q;
                end else begin
                    sr_shift = consume;
                end
            end
            default: begin
                sr_load  = 1'b0;
                sr_shift = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state   <= ST_IDLE;
            hold_q  <= '0;
            bit_cnt <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        bit_cnt <= '0;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (last_bit) begin
                        // A word arriving on the final edge bypasses the hold buffer.
                        bit_cnt <= '0;
                        state   <= accept ? ST_SHIFT : ST_IDLE;
                    end else begin
                        if (consume) bit_cnt <= bit_cnt + CNT_W'(1);
                        if (accept) begin
                            hold_q <= bus.s_data;
                            state  <= ST_SHIFT_HOLD;
                        end
                    end
                end
                ST_SHIFT_HOLD: begin
                    if (last_bit) begin
                        bit_cnt <= '0;
                        state   <= ST_SHIFT;
                    end else if (consume) begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    ser_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk       (clk),
        .arst      (arst),
        .load      (sr_load),
        .load_data (sr_load_data),
        .shift     (sr_shift),
        .bit_out   (cur_bit)
    );

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Scoreboard bench: MSB-first and LSB-first serializers share one stimulus stream.
module tb_seq_bit_serializer;

    localparam int unsigned W = 8;

    typedef struct {
        logic msb;
        logic lsb;
        logic last;
    } exp_t;

    logic clk  = 1'b0;
    logic arst = 1'b0;
    always #5 clk = ~clk;

    seq_bit_serializer_if #(.WIDTH(W)) bus_m ();
    seq_bit_serializer_if #(.WIDTH(W)) bus_l ();

    assign bus_l.s_data  = bus_m.s_data;
    assign bus_l.s_valid = bus_m.s_valid;
    assign bus_l.en      = bus_m.en;

    seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
        .clk  (clk),
        .arst (arst),
        .bus  (bus_m.slave)
    );

    seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
        .clk  (clk),
        .arst (arst),
        .bus  (bus_l.slave)
    );

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   en_rand = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: an accepted word becomes W bits in both orders, last one flagged.
    function automatic void push_word(input logic [W-1:0] w);
        exp_t e;
        for (int i = 0; i < int'(W); i++) begin
            e.msb  = w[W-1-i];
            e.lsb  = w[i];
            e.last = (i == int'(W) - 1);
            q.push_back(e);
        end
    endfunction

    always @(posedge clk) begin
        if (arst && bus_m.s_valid && bus_m.s_ready) push_word(bus_m.s_data);
    end

    // Monitor: the model holds every not-yet-consumed bit, so its size fixes the outputs.
    always @(negedge clk) begin
        if (arst) begin
            logic exp_valid;
            logic exp_ready;
            exp_valid = (q.size() != 0);
            exp_ready = (q.size() <= int'(W));
            check("m_serial_valid", 32'(bus_m.serial_valid), 32'(exp_valid));
            check("l_serial_valid", 32'(bus_l.serial_valid), 32'(exp_valid));
            check("m_s_ready", 32'(bus_m.s_ready), 32'(exp_ready));
            check("l_s_ready", 32'(bus_l.s_ready), 32'(exp_ready));
            if (exp_valid) begin
                check("m_serial_bit", 32'(bus_m.serial_bit), 32'(q[0].msb));
                check("l_serial_bit", 32'(bus_l.serial_bit), 32'(q[0].lsb));
                check("m_word_done", 32'(bus_m.word_done), 32'(bus_m.en & q[0].last));
                check("l_word_done", 32'(bus_l.word_done), 32'(bus_m.en & q[0].last));
                if (bus_m.en) void'(q.pop_front());
            end else begin
                check("m_idle_bit", 32'(bus_m.serial_bit), 32'd0);
                check("l_idle_bit", 32'(bus_l.serial_bit), 32'd0);
                check("m_idle_done", 32'(bus_m.word_done), 32'd0);
                check("l_idle_done", 32'(bus_l.word_done), 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (en_rand) bus_m.en = ($urandom_range(0, 3) != 0);
    endtask

    // Offer one word and return just after the edge that accepts it.
    task automatic send(input logic [W-1:0] w);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        bus_m.s_data  = w;
        bus_m.s_valid = 1'b1;
        while (!acc && n < 200) begin
            acc = bus_m.s_ready;
            step();
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: word %0h not accepted within %0d cycles", w, n);
        end
        bus_m.s_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_serial_valid"}, 32'(bus_m.serial_valid), 32'd0);
        check({tag, "_l_serial_valid"}, 32'(bus_l.serial_valid), 32'd0);
        check({tag, "_m_s_ready"},      32'(bus_m.s_ready),      32'd1);
        check({tag, "_m_serial_bit"},   32'(bus_m.serial_bit),   32'd0);
        check({tag, "_l_serial_bit"},   32'(bus_l.serial_bit),   32'd0);
        check({tag, "_m_word_done"},    32'(bus_m.word_done),    32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_m.s_data  = '0;
        bus_m.s_valid = 1'b0;
        bus_m.en      = 1'b1;
        #1;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1 arst = 1'b1;

        // Single word
        step();
        send(8'hA5);
        repeat (12) step();

        // Back-to-back with valid held across words
        send(8'hA5);
        send(8'h3C);
        repeat (20) step();

        // Stall while the third bit is presented
        send(8'hA5);
        repeat (2) step();
        bus_m.en = 1'b0;
        repeat (3) step();
        bus_m.en = 1'b1;
        repeat (10) step();

        // Single set bit shows ordering difference between the two instances
        send(8'h01);
        repeat (10) step();

        // Second word offered exactly on the final-bit edge
        send(8'hA5);
        repeat (7) step();
        send(8'h3C);
        repeat (12) step();

        // Reset in the middle of a word discards it
        send(8'hA5);
        repeat (4) step();
        #2 arst = 1'b0;
        #1;
        check_reset_outputs("mid");
        q.delete();
        repeat (2) step();
        arst = 1'b1;
        repeat (4) step();

        // Random words, random gaps, random stalls
        en_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) step();
            send(W'($urandom));
        end
        en_rand  = 1'b0;
        bus_m.en = 1'b1;
        repeat (30) step();
        check("drain_empty", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
